// File: rtl/ps2_defs.sv
// Shared scan-code-set-2 constants, decoder state encoding and modifier
// bundle for the PS/2-to-ASCII decoder.
package ps2_defs;

   // Prefix bytes
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_PAUSE = 8'hE1;

   // Modifier make codes (rctrl is SC_EXT followed by SC_CTRL)
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // Bytes that follow E1 in the Pause/Break sequence and carry no meaning
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } dec_state_t;

   typedef struct packed {
      logic lshift;
      logic rshift;
      logic lctrl;
      logic rctrl;
      logic caps_held;
      logic caps_on;
   } mod_t;

   // Keyboard status/acknowledge bytes that never start a key sequence
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
             (b == 8'hFE) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_set2_ascii_lut.sv
// Combinational scan-code-set-2 to ASCII translation. Letters honour
// shift XOR caps and optional ctrl; other keys honour shift only.
module ps2_set2_ascii_lut (
   input  logic [7:0] code,
   input  logic       ext,
   input  logic       shift,
   input  logic       caps,
   input  logic       ctrl,
   output logic [7:0] ascii,
   output logic       hit
);

   logic       letter;
   logic       other;
   logic [7:0] lower;
   logic [7:0] plain;
   logic [7:0] shifted;

   // Classify the code, then apply the modifier rules for its class
   always_comb begin
      // NOTE: every output and temporary gets a default first so no path
      // leaves a value held over, which would infer a latch.
      ascii   = 8'h00;
      hit     = 1'b0;
      letter  = 1'b0;
      other   = 1'b0;
      lower   = 8'h00;
      plain   = 8'h00;
      shifted = 8'h00;

      if (ext) begin
         case (code)
            8'h5A: begin ascii = 8'h0D; hit = 1'b1; end  // keypad Enter
            8'h4A: begin ascii = 8'h2F; hit = 1'b1; end  // keypad '/'
            default: ;
         endcase
      end else begin
         letter = 1'b1;
         case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            default: letter = 1'b0;
         endcase

         other = 1'b1;
         case (code)
            8'h45: begin plain = "0";  shifted = ")";  end
            8'h16: begin plain = "1";  shifted = "!";  end
            8'h1E: begin plain = "2";  shifted = "@";  end
            8'h26: begin plain = "3";  shifted = "#";  end
            8'h25: begin plain = "4";  shifted = "$";  end
            8'h2E: begin plain = "5";  shifted = "%";  end
            8'h36: begin plain = "6";  shifted = "^";  end
            8'h3D: begin plain = "7";  shifted = "&";  end
            8'h3E: begin plain = "8";  shifted = "*";  end
            8'h46: begin plain = "9";  shifted = "(";  end
            8'h4E: begin plain = "-";  shifted = "_";  end
            8'h55: begin plain = "=";  shifted = "+";  end
            8'h54: begin plain = "[";  shifted = "{";  end
            8'h5B: begin plain = "]";  shifted = "}";  end
            8'h5D: begin plain = 8'h5C; shifted = "|"; end
            8'h4C: begin plain = ";";  shifted = ":";  end
            8'h52: begin plain = 8'h27; shifted = 8'h22; end
            8'h41: begin plain = ",";  shifted = "<";  end
            8'h49: begin plain = ".";  shifted = ">";  end
            8'h4A: begin plain = "/";  shifted = "?";  end
            8'h0E: begin plain = 8'h60; shifted = "~";  end
            8'h29: begin plain = " ";  shifted = " ";  end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            default: other = 1'b0;
         endcase

         if (letter) begin
            hit   = 1'b1;
            ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
            if (ctrl)
               ascii = ascii & 8'h1F;
         end else if (other) begin
            hit   = 1'b1;
            ascii = shift ? shifted : plain;
         end
      end
   end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 byte stream decoder: prefix FSM, modifier tracking, ASCII
// translation and a character FIFO with a registered first-word-fall-through
// head drained by a valid/ready handshake.
module ps2_ascii_decoder
   import ps2_defs::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter bit CTRL_EN    = 1'b1,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_valid,
   input  logic [7:0]       scan_code,
   output logic [7:0]       ascii_data,
   output logic             ascii_valid,
   input  logic             ascii_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow,
   input  logic             overflow_clr,
   output logic             caps_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   dec_state_t state, state_nxt;
   logic [2:0] skip, skip_nxt;
   mod_t       mods, mods_nxt;

   logic [7:0] lut_ascii;
   logic       lut_hit;
   logic       push_req;

   // Buffer storage is the head register plus the memory behind it
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] mem_cnt;
   logic             pop;
   logic             load;
   logic             full;
   logic             push_ok;

   ps2_set2_ascii_lut u_lut (
      .code  (scan_code),
      .ext   (state == ST_EXT),
      .shift (mods.lshift | mods.rshift),
      .caps  (mods.caps_on),
      .ctrl  (CTRL_EN && (mods.lctrl || mods.rctrl)),
      .ascii (lut_ascii),
      .hit   (lut_hit)
   );

   // Decoder state, pause skip counter and modifier flags
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= ST_IDLE;
         skip  <= '0;
         mods  <= '0;
      end else begin
         state <= state_nxt;
         skip  <= skip_nxt;
         mods  <= mods_nxt;
      end
   end

   // Next-state, modifier updates and push request for each received byte
   always_comb begin
      state_nxt = state;
      skip_nxt  = skip;
      mods_nxt  = mods;
      push_req  = 1'b0;

      if (scan_valid) begin
         case (state)
            ST_IDLE: begin
               if (scan_code == SC_EXT) begin
                  state_nxt = ST_EXT;
               end else if (scan_code == SC_BRK) begin
                  state_nxt = ST_BRK;
               end else if (scan_code == SC_PAUSE) begin
                  state_nxt = ST_PAUSE;
                  skip_nxt  = PAUSE_SKIP;
               end else if (!is_ignored(scan_code)) begin
                  case (scan_code)
                     SC_LSHIFT: mods_nxt.lshift = 1'b1;
                     SC_RSHIFT: mods_nxt.rshift = 1'b1;
                     SC_CTRL:   mods_nxt.lctrl  = 1'b1;
                     SC_CAPS: begin
                        // Typematic repeats arrive while held; toggle once
                        if (!mods.caps_held)
                           mods_nxt.caps_on = ~mods.caps_on;
                        mods_nxt.caps_held = 1'b1;
                     end
                     default: push_req = lut_hit;
                  endcase
               end
            end

            ST_EXT: begin
               if (scan_code == SC_BRK) begin
                  state_nxt = ST_EXT_BRK;
               end else begin
                  state_nxt = ST_IDLE;
                  if (scan_code == SC_CTRL)
                     mods_nxt.rctrl = 1'b1;
                  else
                     push_req = lut_hit;
               end
            end

            ST_BRK: begin
               state_nxt = ST_IDLE;
               case (scan_code)
                  SC_LSHIFT: mods_nxt.lshift    = 1'b0;
                  SC_RSHIFT: mods_nxt.rshift    = 1'b0;
                  SC_CTRL:   mods_nxt.lctrl     = 1'b0;
                  SC_CAPS:   mods_nxt.caps_held = 1'b0;
                  default: ;
               endcase
            end

            ST_EXT_BRK: begin
               state_nxt = ST_IDLE;
               if (scan_code == SC_CTRL)
                  mods_nxt.rctrl = 1'b0;
            end

            ST_PAUSE: begin
               skip_nxt = skip - 3'd1;
               if (skip <= 3'd1)
                  state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign fifo_count = mem_cnt + {{(CNT_W-1){1'b0}}, ascii_valid};
   assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign pop        = ascii_valid & ascii_ready;
   assign push_ok    = push_req & (~full | pop);
   assign load       = (mem_cnt != '0) & (~ascii_valid | pop);
   assign caps_state = mods.caps_on;

   // Character memory write port
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; entries are only read
      // after being written, tracked by the pointers and count.
      if (push_ok)
         mem[wr_ptr] <= lut_ascii;
   end

   // FIFO pointers, count, registered head and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_cnt     <= '0;
         ascii_data  <= '0;
         ascii_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (load)
            rd_ptr <= rd_ptr + 1'b1;

         if (push_ok && !load)
            mem_cnt <= mem_cnt + 1'b1;
         else if (!push_ok && load)
            mem_cnt <= mem_cnt - 1'b1;

         if (load) begin
            ascii_data  <= mem[rd_ptr];
            ascii_valid <= 1'b1;
         end else if (pop) begin
            ascii_valid <= 1'b0;
         end

         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder (FIFO_DEPTH=8, CTRL_EN=1).
module tb_ps2_ascii_decoder;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          scan_valid;
   logic [7:0]    scan_code;
   logic [7:0]    ascii_data;
   logic          ascii_valid;
   logic          ascii_ready;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          overflow_clr;
   logic          caps_state;

   int total = 0;
   int bad   = 0;

   ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .CTRL_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .scan_valid   (scan_valid),
      .scan_code    (scan_code),
      .ascii_data   (ascii_data),
      .ascii_valid  (ascii_valid),
      .ascii_ready  (ascii_ready),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .caps_state   (caps_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One-cycle strobe of a byte; returns at the negedge after the sampling edge
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scan_valid = 1'b1;
      scan_code  = b;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   // Wait (bounded) for a character, compare it, then pop it
   task automatic expect_char(input string tag, input logic [7:0] exp);
      int n = 0;
      while (!ascii_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".valid"}, ascii_valid, 1);
      check(tag, ascii_data, exp);
      if (ascii_valid) begin
         ascii_ready = 1'b1;
         @(negedge clk);
         ascii_ready = 1'b0;
      end
   endtask

   task automatic expect_empty(input string tag);
      idle(4);
      check(tag, fifo_count, 0);
   endtask

   initial begin
      reset        = 1'b1;
      scan_valid   = 1'b0;
      scan_code    = 8'h00;
      ascii_ready  = 1'b0;
      overflow_clr = 1'b0;
      idle(3);
      reset = 1'b0;

      // Reset state
      check("rst.valid", ascii_valid, 0);
      check("rst.data", ascii_data, 0);
      check("rst.count", fifo_count, 0);
      check("rst.ovf", overflow, 0);
      check("rst.caps", caps_state, 0);

      // Single make: written at the sampling edge, head valid one edge later
      send(8'h1C);
      check("lat.valid_early", ascii_valid, 0);
      check("lat.count", fifo_count, 1);
      @(negedge clk);
      check("lat.valid", ascii_valid, 1);
      check("lat.data", ascii_data, 8'h61);
      send(8'hF0); send(8'h1C);
      idle(3);
      check("brk.count", fifo_count, 1);
      expect_char("a1", 8'h61);
      check("a1.count_after", fifo_count, 0);

      // Shift held then released
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12); send(8'h1C);
      expect_char("shift.A", 8'h41);
      expect_char("shift.a", 8'h61);

      // Caps lock, and shift cancelling caps on letters
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
      expect_char("caps.A", 8'h41);
      check("caps.on", caps_state, 1);
      send(8'h12); send(8'h1C);
      expect_char("caps_shift.a", 8'h61);
      send(8'hF0); send(8'h12);
      send(8'h58); send(8'hF0); send(8'h58);
      idle(1);
      check("caps.off", caps_state, 0);

      // Overflow: DEPTH+1 makes with no reader
      repeat (DEPTH + 1) send(8'h1C);
      idle(2);
      check("ovf.count", fifo_count, DEPTH);
      check("ovf.flag", overflow, 1);
      for (int i = 0; i < DEPTH; i++) expect_char("ovf.drain", 8'h61);
      check("ovf.empty", ascii_valid, 0);
      check("ovf.sticky", overflow, 1);
      @(negedge clk); overflow_clr = 1'b1;
      @(negedge clk); overflow_clr = 1'b0;
      check("ovf.clr", overflow, 0);

      // Full FIFO: push and pop in the same cycle both succeed
      repeat (DEPTH) send(8'h1C);
      idle(2);
      check("fullpp.count_pre", fifo_count, DEPTH);
      @(negedge clk);
      scan_valid  = 1'b1;
      scan_code   = 8'h32;
      ascii_ready = 1'b1;
      @(negedge clk);
      scan_valid  = 1'b0;
      ascii_ready = 1'b0;
      check("fullpp.count", fifo_count, DEPTH);
      check("fullpp.ovf", overflow, 0);
      for (int i = 0; i < DEPTH - 1; i++) expect_char("fullpp.a", 8'h61);
      expect_char("fullpp.b", 8'h62);

      // Extended keys
      send(8'hE0); send(8'h5A);
      expect_char("ext.enter", 8'h0D);
      send(8'hE0); send(8'h75);
      expect_empty("ext.up_dropped");
      send(8'hE0); send(8'h4A);
      expect_char("ext.slash", 8'h2F);

      // Pause sequence leaves no output and no stuck ctrl
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C);
      expect_char("pause.a", 8'h61);
      expect_empty("pause.only_one");

      // Ignored status byte, then a normal make
      send(8'hAA); send(8'h1C);
      expect_char("ign.a", 8'h61);
      expect_empty("ign.only_one");

      // Ctrl (left and right) on letters
      send(8'h14); send(8'h21);
      expect_char("lctrl.c", 8'h03);
      send(8'hF0); send(8'h14); send(8'h21);
      expect_char("lctrl.rel", 8'h63);
      send(8'hE0); send(8'h14); send(8'h21);
      expect_char("rctrl.c", 8'h03);
      send(8'hE0); send(8'hF0); send(8'h14); send(8'h21);
      expect_char("rctrl.rel", 8'h63);

      // Reset mid-prefix and with a queued character
      send(8'h1C); send(8'hE0); send(8'hF0);
      pulse_reset();
      check("midrst.count", fifo_count, 0);
      check("midrst.valid", ascii_valid, 0);
      send(8'h1C);
      expect_char("midrst.a", 8'h61);
      expect_empty("midrst.only_one");

      // Caps typematic repeat toggles only once
      send(8'h58); send(8'h58);
      idle(1);
      check("caps_rpt.on", caps_state, 1);
      send(8'hF0); send(8'h58); send(8'h58);
      idle(1);
      check("caps_rpt.off", caps_state, 0);
      expect_empty("caps_rpt.no_char");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
